// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared VRAM widths and read-owner tag type for the VDP
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_RENDER} vram_owner_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// rtl/vram_rd_pipe.sv - read-owner tag delay line matching the VRAM read latency
module vram_rd_pipe
  import vdp_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       flush_n,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_out
);

  vram_owner_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!flush_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= vram_owner_t'(tag_in);
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - CPU/renderer VRAM arbiter with slot reservation and starvation guard
// Optional grant/stall counters: define VRAM_ARB_STATS_EN.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int ADDR_W          = VRAM_ADDR_W,
  parameter int DATA_W          = VRAM_DATA_W,
  parameter int CPU_SLOT_PERIOD = 4,
  parameter int RD_LAT          = 1,
  parameter int STARVE_LIMIT    = 16
) (
  input  logic              clk,
  input  logic              btnCpuReset,
  input  logic              active,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_gnt,
  output logic              render_rvalid,
  output logic [DATA_W-1:0] render_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  output logic              vram_en,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_grants,
  output logic [15:0]       stat_render_grants,
  output logic [15:0]       stat_cpu_stalls
`endif
);

  localparam int SLOT_W = $clog2(CPU_SLOT_PERIOD);
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CPU_SLOT_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT - 1);

  logic [SLOT_W-1:0] slot_q;
  logic [WAIT_W-1:0] wait_q;
  logic              force_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] render_rdata_q;
  vram_owner_t       tag_in;
  logic [1:0]        tail;

  // Blanking and the reserved slot share the same CPU-first ordering.
  always_comb begin
    cpu_gnt    = 1'b0;
    render_gnt = 1'b0;
    if (!btnCpuReset) begin
      cpu_gnt    = 1'b0;
    end else if (force_q && cpu_req) begin
      cpu_gnt    = 1'b1;
    end else if (!active || slot_q == LAST_SLOT) begin
      cpu_gnt    = cpu_req;
      render_gnt = !cpu_req && render_req;
    end else begin
      render_gnt = render_req;
      cpu_gnt    = !render_req && cpu_req;
    end
  end

  always_comb begin
    tag_in = OWN_NONE;
    if (cpu_gnt && !cpu_we) tag_in = OWN_CPU;
    else if (render_gnt)    tag_in = OWN_RENDER;
  end

  assign cpu_starve = btnCpuReset && force_q && cpu_req;
  assign vram_en    = cpu_gnt || render_gnt;
  assign vram_we    = cpu_gnt && cpu_we;
  assign vram_addr  = cpu_gnt ? cpu_addr : (render_gnt ? render_addr : '0);
  assign vram_wdata = vram_we ? cpu_wdata : '0;

  vram_rd_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .flush_n (btnCpuReset),
    .tag_in  (tag_in),
    .tag_out (tail)
  );

  assign cpu_rvalid    = btnCpuReset && (tail == OWN_CPU);
  assign render_rvalid = btnCpuReset && (tail == OWN_RENDER);
  assign cpu_rdata     = !btnCpuReset ? '0 : (cpu_rvalid ? vram_rdata : cpu_rdata_q);
  assign render_rdata  = !btnCpuReset ? '0 : (render_rvalid ? vram_rdata : render_rdata_q);

  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      slot_q         <= '0;
      wait_q         <= '0;
      force_q        <= 1'b0;
      cpu_rdata_q    <= '0;
      render_rdata_q <= '0;
    end else begin
      if (!active || slot_q == LAST_SLOT) slot_q <= '0;
      else                                slot_q <= slot_q + 1'b1;
      // wait_q parks at its limit once the force flag is armed.
      if (cpu_req && !cpu_gnt) begin
        if (wait_q == WAIT_MAX) force_q <= 1'b1;
        else                    wait_q  <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (cpu_gnt)       force_q        <= 1'b0;
      if (cpu_rvalid)    cpu_rdata_q    <= vram_rdata;
      if (render_rvalid) render_rdata_q <= vram_rdata;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!btnCpuReset) begin
      stat_cpu_grants    <= '0;
      stat_render_grants <= '0;
      stat_cpu_stalls    <= '0;
    end else begin
      if (cpu_gnt && stat_cpu_grants != 16'hFFFF)
        stat_cpu_grants <= stat_cpu_grants + 16'd1;
      if (render_gnt && stat_render_grants != 16'hFFFF)
        stat_render_grants <= stat_render_grants + 16'd1;
      if (cpu_req && !cpu_gnt && stat_cpu_stalls != 16'hFFFF)
        stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed and randomized checks of vram_arbiter against a reference model
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          btnCpuReset = 1'b0;
  logic          active = 1'b0, render_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] render_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, vram_rdata = '0;

  logic          render_gnt, render_rvalid, cpu_gnt, cpu_rvalid, cpu_starve, vram_en, vram_we;
  logic [DW-1:0] render_rdata, cpu_rdata, vram_wdata;
  logic [AW-1:0] vram_addr;

  logic          render_gnt_8, render_rvalid_8, cpu_gnt_8, cpu_rvalid_8, cpu_starve_8;
  logic          vram_en_8, vram_we_8;
  logic [DW-1:0] render_rdata_8, cpu_rdata_8, vram_wdata_8;
  logic [AW-1:0] vram_addr_8;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] mem     [16384];
  logic [DW-1:0] ref_mem [16384];

  // VRAM macro stand-in: one-cycle registered read.
  always @(posedge clk) begin
    if (vram_en) begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      else         vram_rdata     <= mem[vram_addr];
    end
  end

  vram_arbiter #(.CPU_SLOT_PERIOD(4), .RD_LAT(1), .STARVE_LIMIT(16)) u_dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .active(active),
    .render_req(render_req), .render_addr(render_addr), .render_gnt(render_gnt),
    .render_rvalid(render_rvalid), .render_rdata(render_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_starve(cpu_starve),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  vram_arbiter #(.CPU_SLOT_PERIOD(8), .RD_LAT(1), .STARVE_LIMIT(4)) u_dut8 (
    .clk(clk), .btnCpuReset(btnCpuReset), .active(active),
    .render_req(render_req), .render_addr(render_addr), .render_gnt(render_gnt_8),
    .render_rvalid(render_rvalid_8), .render_rdata(render_rdata_8),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_8), .cpu_rvalid(cpu_rvalid_8), .cpu_rdata(cpu_rdata_8), .cpu_starve(cpu_starve_8),
    .vram_en(vram_en_8), .vram_we(vram_we_8), .vram_addr(vram_addr_8), .vram_wdata(vram_wdata_8),
    .vram_rdata(vram_rdata)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    active = 1'b0; render_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    btnCpuReset = 1'b0;
    next_cycle();
    next_cycle();
    btnCpuReset = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    next_cycle();
    idle();
    ref_mem[a] = d;
  endtask

  task automatic test_reset;
    btnCpuReset = 1'b0;
    active = 1'b1; render_req = 1'b1; cpu_req = 1'b1; cpu_addr = 14'h0011;
    #3;
    total++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt actual=%0b expected=0", cpu_gnt); else passed++;
    total++; if (render_gnt !== 1'b0) $display("FAIL rst_render_gnt actual=%0b expected=0", render_gnt); else passed++;
    total++; if (vram_en !== 1'b0) $display("FAIL rst_vram_en actual=%0b expected=0", vram_en); else passed++;
    total++; if (vram_addr !== '0) $display("FAIL rst_vram_addr actual=%0h expected=0", vram_addr); else passed++;
    total++; if ({cpu_rvalid, render_rvalid, cpu_starve} !== 3'b000)
      $display("FAIL rst_flags actual=%0b expected=0", {cpu_rvalid, render_rvalid, cpu_starve}); else passed++;
    total++; if ({cpu_rdata, render_rdata} !== '0)
      $display("FAIL rst_rdata actual=%0h expected=0", {cpu_rdata, render_rdata}); else passed++;
    total++; if (cpu_gnt_8 !== 1'b0) $display("FAIL rst_cpu_gnt_8 actual=%0b expected=0", cpu_gnt_8); else passed++;
    next_cycle();
    idle();
    btnCpuReset = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_read_blank;
    preload(14'h0123, 8'h5A);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    #3;
    total++; if (cpu_gnt !== 1'b1) $display("FAIL t1_cpu_gnt actual=%0b expected=1", cpu_gnt); else passed++;
    total++; if (render_gnt !== 1'b0) $display("FAIL t1_render_gnt actual=%0b expected=0", render_gnt); else passed++;
    total++; if ({vram_en, vram_we} !== 2'b10) $display("FAIL t1_vram_en_we actual=%0b expected=10", {vram_en, vram_we}); else passed++;
    total++; if (vram_addr !== 14'h0123) $display("FAIL t1_vram_addr actual=%0h expected=0123", vram_addr); else passed++;
    next_cycle();
    cpu_req = 1'b0;
    #3;
    total++; if (cpu_rvalid !== 1'b1) $display("FAIL t1_cpu_rvalid actual=%0b expected=1", cpu_rvalid); else passed++;
    total++; if (cpu_rdata !== 8'h5A) $display("FAIL t1_cpu_rdata actual=%0h expected=5a", cpu_rdata); else passed++;
    total++; if (render_rvalid !== 1'b0) $display("FAIL t1_render_rvalid actual=%0b expected=0", render_rvalid); else passed++;
    next_cycle();
    #3;
    total++; if (cpu_rvalid !== 1'b0) $display("FAIL t1_rvalid_pulse actual=%0b expected=0", cpu_rvalid); else passed++;
    total++; if (cpu_rdata !== 8'h5A) $display("FAIL t1_rdata_hold actual=%0h expected=5a", cpu_rdata); else passed++;
    next_cycle();
  endtask

  task automatic test_slot_pattern;
    logic [6:0] act_pat;
    logic [6:0] cpu_pat;
    act_pat = 7'b1111011;
    cpu_pat = 7'b1000100;
    idle();
    next_cycle();
    active = 1'b1; render_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    render_addr = 14'h0001; cpu_addr = 14'h0002;
    for (int k = 0; k < 12; k++) begin
      #3;
      total++; if (cpu_gnt !== (k % 4 == 3)) $display("FAIL t2_cpu_gnt k=%0d actual=%0b expected=%0b", k, cpu_gnt, (k % 4 == 3)); else passed++;
      total++; if (render_gnt !== (k % 4 != 3)) $display("FAIL t2_render_gnt k=%0d actual=%0b expected=%0b", k, render_gnt, (k % 4 != 3)); else passed++;
      next_cycle();
    end
    // active drops mid-slot, then restarts at slot 0
    for (int k = 0; k < 7; k++) begin
      active = act_pat[k];
      #3;
      total++; if (cpu_gnt !== cpu_pat[k]) $display("FAIL t2_edge_cpu k=%0d actual=%0b expected=%0b", k, cpu_gnt, cpu_pat[k]); else passed++;
      total++; if (render_gnt !== !cpu_pat[k]) $display("FAIL t2_edge_render k=%0d actual=%0b expected=%0b", k, render_gnt, !cpu_pat[k]); else passed++;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 8; k++) preload(AW'(k), DW'($urandom));
    active = 1'b1;
    for (int k = 0; k < 9; k++) begin
      render_req = (k < 8);
      render_addr = AW'(k);
      #3;
      if (k < 8) begin
        total++; if (render_gnt !== 1'b1) $display("FAIL t3_render_gnt k=%0d actual=%0b expected=1", k, render_gnt); else passed++;
      end
      if (k > 0) begin
        total++; if (render_rvalid !== 1'b1) $display("FAIL t3_rvalid k=%0d actual=%0b expected=1", k, render_rvalid); else passed++;
        total++; if (render_rdata !== ref_mem[k-1]) $display("FAIL t3_rdata k=%0d actual=%0h expected=%0h", k, render_rdata, ref_mem[k-1]); else passed++;
      end
      total++; if (cpu_rvalid !== 1'b0) $display("FAIL t3_cpu_rvalid k=%0d actual=%0b expected=0", k, cpu_rvalid); else passed++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_write_read;
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'hA5;
    #3;
    total++; if (cpu_gnt !== 1'b1) $display("FAIL t4_wr_gnt actual=%0b expected=1", cpu_gnt); else passed++;
    total++; if (vram_we !== 1'b1) $display("FAIL t4_vram_we actual=%0b expected=1", vram_we); else passed++;
    total++; if (vram_wdata !== 8'hA5) $display("FAIL t4_vram_wdata actual=%0h expected=a5", vram_wdata); else passed++;
    total++; if (vram_addr !== 14'h3FFF) $display("FAIL t4_vram_addr actual=%0h expected=3fff", vram_addr); else passed++;
    ref_mem[14'h3FFF] = 8'hA5;
    next_cycle();
    cpu_we = 1'b0;
    #3;
    total++; if ({cpu_gnt, vram_we} !== 2'b10) $display("FAIL t4_rd_gnt_we actual=%0b expected=10", {cpu_gnt, vram_we}); else passed++;
    total++; if (cpu_rvalid !== 1'b0) $display("FAIL t4_wr_no_rvalid actual=%0b expected=0", cpu_rvalid); else passed++;
    next_cycle();
    cpu_req = 1'b0;
    #3;
    total++; if (cpu_rvalid !== 1'b1) $display("FAIL t4_rvalid actual=%0b expected=1", cpu_rvalid); else passed++;
    total++; if (cpu_rdata !== 8'hA5) $display("FAIL t4_rdata actual=%0h expected=a5", cpu_rdata); else passed++;
    total++; if (render_rvalid !== 1'b0) $display("FAIL t4_render_rvalid actual=%0b expected=0", render_rvalid); else passed++;
    next_cycle();
  endtask

  task automatic test_starve;
    int pulses;
    pulses = 0;
    do_reset();
    next_cycle();
    active = 1'b1; render_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #3;
      total++; if (cpu_gnt_8 !== (k % 8 == 4 || k % 8 == 7))
        $display("FAIL t5_cpu_gnt k=%0d actual=%0b expected=%0b", k, cpu_gnt_8, (k % 8 == 4 || k % 8 == 7)); else passed++;
      total++; if (cpu_starve_8 !== (k % 8 == 4))
        $display("FAIL t5_starve k=%0d actual=%0b expected=%0b", k, cpu_starve_8, (k % 8 == 4)); else passed++;
      if (k < 7 && cpu_starve_8 === 1'b1) pulses++;
      next_cycle();
    end
    total++; if (pulses !== 1) $display("FAIL t5_pulse_count actual=%0d expected=1", pulses); else passed++;
    idle();
    next_cycle();
  endtask

  task automatic test_reset_inflight;
    active = 1'b1; render_req = 1'b1; cpu_req = 1'b0; render_addr = 14'h0005;
    #3;
    total++; if (render_gnt !== 1'b1) $display("FAIL t6_render_gnt actual=%0b expected=1", render_gnt); else passed++;
    next_cycle();
    btnCpuReset = 1'b0;
    render_req = 1'b0;
    #3;
    total++; if (render_rvalid !== 1'b0) $display("FAIL t6_rvalid_in_reset actual=%0b expected=0", render_rvalid); else passed++;
    total++; if ({render_rdata, cpu_rdata, vram_en, cpu_gnt, render_gnt} !== '0)
      $display("FAIL t6_outputs_zero actual=%0h expected=0", {render_rdata, cpu_rdata, vram_en, cpu_gnt, render_gnt}); else passed++;
    next_cycle();
    btnCpuReset = 1'b1;
    render_req = 1'b1; cpu_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3;
      total++; if (cpu_gnt !== (k == 3)) $display("FAIL t6_slot_cpu k=%0d actual=%0b expected=%0b", k, cpu_gnt, (k == 3)); else passed++;
      if (k == 0) begin
        total++; if (render_rvalid !== 1'b0) $display("FAIL t6_no_stale_rvalid actual=%0b expected=0", render_rvalid); else passed++;
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_random;
    int m_slot, m_wait, eg, p_own;
    bit m_force, cpu_pend, ren_pend;
    logic [DW-1:0] p_data, last_cpu, last_ren;
    logic [AW-1:0] g_addr;
    do_reset();
    for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom));
    do_reset();
    m_slot = 0; m_wait = 0; m_force = 0; p_own = 0; p_data = '0;
    last_cpu = '0; last_ren = '0; cpu_pend = 0; ren_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cpu_pend && $urandom_range(0, 1) == 1) begin
        cpu_pend = 1; cpu_we = 1'($urandom); cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = DW'($urandom);
      end
      if (!ren_pend && $urandom_range(0, 3) != 0) begin
        ren_pend = 1; render_addr = AW'($urandom_range(0, 15));
      end
      cpu_req = cpu_pend;
      render_req = ren_pend;
      if ($urandom_range(0, 7) == 0) active = !active;
      if (m_force && cpu_req)                 eg = 1;
      else if (!active || m_slot == 3)        eg = cpu_req ? 1 : (render_req ? 2 : 0);
      else                                    eg = render_req ? 2 : (cpu_req ? 1 : 0);
      g_addr = (eg == 1) ? cpu_addr : render_addr;
      if (p_own == 1) last_cpu = p_data;
      if (p_own == 2) last_ren = p_data;
      #3;
      total++; if ({cpu_gnt, render_gnt} !== {eg == 1, eg == 2})
        $display("FAIL rnd_gnt n=%0d actual=%0b expected=%0b", n, {cpu_gnt, render_gnt}, {eg == 1, eg == 2}); else passed++;
      total++; if ({vram_en, vram_we} !== {eg != 0, eg == 1 && cpu_we})
        $display("FAIL rnd_en_we n=%0d actual=%0b expected=%0b", n, {vram_en, vram_we}, {eg != 0, eg == 1 && cpu_we}); else passed++;
      if (eg != 0) begin
        total++; if (vram_addr !== g_addr) $display("FAIL rnd_addr n=%0d actual=%0h expected=%0h", n, vram_addr, g_addr); else passed++;
      end
      if (eg == 1 && cpu_we) begin
        total++; if (vram_wdata !== cpu_wdata) $display("FAIL rnd_wdata n=%0d actual=%0h expected=%0h", n, vram_wdata, cpu_wdata); else passed++;
      end
      total++; if (cpu_starve !== (m_force && cpu_req)) $display("FAIL rnd_starve n=%0d actual=%0b expected=%0b", n, cpu_starve, m_force && cpu_req); else passed++;
      total++; if ({cpu_rvalid, render_rvalid} !== {p_own == 1, p_own == 2})
        $display("FAIL rnd_rvalid n=%0d actual=%0b expected=%0b", n, {cpu_rvalid, render_rvalid}, {p_own == 1, p_own == 2}); else passed++;
      total++; if (cpu_rdata !== last_cpu) $display("FAIL rnd_cpu_rdata n=%0d actual=%0h expected=%0h", n, cpu_rdata, last_cpu); else passed++;
      total++; if (render_rdata !== last_ren) $display("FAIL rnd_render_rdata n=%0d actual=%0h expected=%0h", n, render_rdata, last_ren); else passed++;
      p_own = (eg == 1) ? (cpu_we ? 0 : 1) : eg;
      p_data = ref_mem[g_addr];
      if (eg == 1 && cpu_we) ref_mem[g_addr] = cpu_wdata;
      if (cpu_req && eg != 1) begin
        if (m_wait == 15) m_force = 1;
        else m_wait++;
      end else begin
        m_wait = 0;
      end
      if (eg == 1) begin m_force = 0; cpu_pend = 0; end
      if (eg == 2) ren_pend = 0;
      m_slot = active ? (m_slot + 1) % 4 : 0;
      next_cycle();
    end
    idle();
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_cpu_read_blank();
    test_slot_pattern();
    test_back_to_back();
    test_write_read();
    test_starve();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
